// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select encodings, flag bit positions and
// the state set of the shift-add multiply sequencer.
package alu_pkg;

    localparam logic [4:0] FS_PASSA = 5'b10000;
    localparam logic [4:0] FS_ADD32 = 5'b10100;
    localparam logic [4:0] FS_LSL32 = 5'b11011;
    localparam logic [4:0] FS_LSR32 = 5'b11100;

    // Flag register layout is {Z,C,N,O}, MSB first.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHL,
        SHR,
        FIN
    } state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// multiply sequencer (slave).
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTHxWIDTH shift-add multiplier that borrows the shared ALU for every step.
// Optional macro ALU_MULSEQ_EARLY_EXIT_EN ends the loop once the multiplier runs out of set bits.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_mul_sequencer_if.slave   bus,
    output logic [2*WIDTH-1:0]   o_aluA,
    output logic [2*WIDTH-1:0]   o_aluB,
    output logic [4:0]           o_aluFunSel,
    output logic                 o_aluWF,
    input  logic [2*WIDTH-1:0]   i_aluOut
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_nextState;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_prod   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
                        r_mplier <= bus.multiplier;
                        r_cnt    <= '0;
                    end
                end
                ADD: r_prod <= i_aluOut;
                SHL: r_mcand <= i_aluOut;
                SHR: begin
                    r_mplier <= i_aluOut[WIDTH-1:0];
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                FIN: r_result <= r_prod;
                default: ;
            endcase
        end
    end

    // ALU drive depends only on the registered state; Start only steers the next state.
    always_comb begin
        w_nextState = r_state;
        o_aluA      = '0;
        o_aluB      = '0;
        o_aluFunSel = FS_PASSA;
        o_aluWF     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = bus.multiplier[0] ? ADD : SHL;
                end
            end
            ADD: begin
                o_aluA      = r_prod;
                o_aluB      = r_mcand;
                o_aluFunSel = FS_ADD32;
                w_nextState = SHL;
            end
            SHL: begin
                o_aluA      = r_mcand;
                o_aluFunSel = FS_LSL32;
                w_nextState = SHR;
            end
            SHR: begin
                o_aluA      = {{WIDTH{1'b0}}, r_mplier};
                o_aluFunSel = FS_LSR32;
`ifdef ALU_MULSEQ_EARLY_EXIT_EN
                if (r_cnt == CNT_LAST || i_aluOut[WIDTH-1:0] == '0) begin
                    w_nextState = FIN;
                end else begin
                    w_nextState = i_aluOut[0] ? ADD : SHL;
                end
`else
                if (r_cnt == CNT_LAST) begin
                    w_nextState = FIN;
                end else begin
                    w_nextState = i_aluOut[0] ? ADD : SHL;
                end
`endif
            end
            FIN: begin
                o_aluA      = r_prod;
                o_aluFunSel = FS_PASSA;
                o_aluWF     = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The product is presented straight from r_prod during FIN so Done and Result coincide.
    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == FIN);
    assign bus.result = (r_state == FIN) ? r_prod : r_result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer with a behavioural 32-bit ALU beside it.
// Expected latencies follow the ALU_MULSEQ_EARLY_EXIT_EN setting of the build.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

`ifdef ALU_MULSEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [4:0]  aluFunSel;
    logic        aluWF;
    logic [31:0] aluOut;
    logic [3:0]  aluFlags = 4'b0000;

    int compareCount = 0;
    int failCount    = 0;

    int          busyCycles;
    int          doneCount;
    int          wfBad;
    logic        timedOut;
    logic [31:0] resultAtDone;

    alu_mul_sequencer_if #(.WIDTH(16)) bus ();

    alu_mul_sequencer #(.WIDTH(16)) dut (
        .Clock       (clk),
        .Reset       (reset),
        .bus         (bus.slave),
        .o_aluA      (aluA),
        .o_aluB      (aluB),
        .o_aluFunSel (aluFunSel),
        .o_aluWF     (aluWF),
        .i_aluOut    (aluOut)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only the functions the sequencer uses, flags latched on WF.
    always_comb begin
        case (aluFunSel)
            FS_PASSA: aluOut = aluA;
            FS_ADD32: aluOut = aluA + aluB;
            FS_LSL32: aluOut = aluA << 1;
            FS_LSR32: aluOut = aluA >> 1;
            default:  aluOut = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        if (aluWF) begin
            aluFlags[FLAG_Z] <= (aluOut == 32'd0);
            aluFlags[FLAG_N] <= aluOut[31];
            aluFlags[FLAG_C] <= 1'b0;
            aluFlags[FLAG_O] <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request and follows it while Busy; optionally re-pulses Start or hits Reset mid-run.
    task automatic applyStimulus(input logic [15:0] mc, input logic [15:0] mp,
                                 input int glitchAt, input int resetAt);
        busyCycles   = 0;
        doneCount    = 0;
        wfBad        = 0;
        timedOut     = 1'b0;
        resultAtDone = 32'hXXXX_XXXX;
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (bus.busy === 1'b1) begin
            busyCycles++;
            if (bus.done === 1'b1) begin
                doneCount++;
                resultAtDone = bus.result;
            end
            if (aluWF !== bus.done) wfBad++;
            if (busyCycles == glitchAt) begin
                bus.start        = 1'b1;
                bus.multiplicand = 16'd2;
                bus.multiplier   = 16'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (busyCycles == resetAt) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                break;
            end
            if (busyCycles >= 200) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        checkOutput("noTimeout", {31'd0, timedOut}, 32'd0);
    endtask

    task automatic checkRun(input string tag, input logic [31:0] product, input int busyExp,
                            input logic zExp, input logic nExp);
        checkOutput({tag, ".busyCycles"}, busyCycles, busyExp);
        checkOutput({tag, ".doneCount"}, doneCount, 32'd1);
        checkOutput({tag, ".resultAtDone"}, resultAtDone, product);
        checkOutput({tag, ".resultHeld"}, bus.result, product);
        checkOutput({tag, ".wfOnlyInFin"}, wfBad, 32'd0);
        checkOutput({tag, ".idleFunSel"}, {27'd0, aluFunSel}, {27'd0, FS_PASSA});
        checkOutput({tag, ".flagZ"}, {31'd0, aluFlags[FLAG_Z]}, {31'd0, zExp});
        checkOutput({tag, ".flagN"}, {31'd0, aluFlags[FLAG_N]}, {31'd0, nExp});
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = 16'd0;
        bus.multiplier   = 16'd0;
        reset            = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        $display("[TB] reset state");
        checkOutput("rst.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst.done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst.result", bus.result, 32'd0);
        checkOutput("rst.aluA", aluA, 32'd0);
        checkOutput("rst.aluB", aluB, 32'd0);
        checkOutput("rst.funSel", {27'd0, aluFunSel}, 32'h10);
        checkOutput("rst.wf", {31'd0, aluWF}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] 3 x 5");
        applyStimulus(16'h0003, 16'h0005, 0, 0);
        checkRun("m3x5", 32'h0000_000F, EARLY ? 9 : 35, 1'b0, 1'b0);

        $display("[TB] FFFF x FFFF");
        applyStimulus(16'hFFFF, 16'hFFFF, 0, 0);
        checkRun("mFFFF", 32'hFFFE_0001, 49, 1'b0, 1'b1);

        $display("[TB] 1234 x 0");
        applyStimulus(16'h1234, 16'h0000, 0, 0);
        checkRun("mZero", 32'h0000_0000, EARLY ? 3 : 33, 1'b1, 1'b0);

        $display("[TB] 7 x 9 with ignored Start at busy cycle 5");
        applyStimulus(16'h0007, 16'h0009, 5, 0);
        checkRun("m7x9", 32'h0000_003F, EARLY ? 11 : 35, 1'b0, 1'b0);

        $display("[TB] FF x FF aborted by reset at busy cycle 10");
        applyStimulus(16'h00FF, 16'h00FF, 0, 10);
        checkOutput("abort.busyCycles", busyCycles, 32'd10);
        checkOutput("abort.doneCount", doneCount, 32'd0);
        checkOutput("abort.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort.done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort.result", bus.result, 32'd0);
        checkOutput("abort.aluWF", {31'd0, aluWF}, 32'd0);
        @(posedge clk); #1;
        checkOutput("abort.stillIdle", {31'd0, bus.busy}, 32'd0);

        $display("[TB] 2 x 3 after abort");
        applyStimulus(16'h0002, 16'h0003, 0, 0);
        checkRun("m2x3", 32'h0000_0006, EARLY ? 7 : 35, 1'b0, 1'b0);

        $display("[TB] 1234 x 1");
        applyStimulus(16'h1234, 16'h0001, 0, 0);
        checkRun("m1234x1", 32'h0000_1234, EARLY ? 4 : 34, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
